// File: rtl/ch0re_branch_unit_pkg.sv
// Shared types for the ch0re branch unit: ALU op encoding, FSM states, PC constants.
// Optional performance counters are enabled with CH0RE_BRU_PERF_EN.
package ch0re_types;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_EQ,
    ALU_NE,
    ALU_LT,
    ALU_GE,
    ALU_LTU,
    ALU_GEU
  } alu_op_e;

  typedef enum logic [1:0] {
    BRU_IDLE,
    BRU_REDIRECT,
    BRU_SQUASH
  } bru_state_e;

  // The ALU already picked signed/unsigned compare, so LT/LTU and GE/GEU collapse.
  function automatic logic branch_taken(alu_op_e op, logic zero, logic less);
    logic t;
    t = 1'b0;
    case (op)
      ALU_EQ:          t = zero;
      ALU_NE:          t = ~zero;
      ALU_LT, ALU_LTU: t = less;
      ALU_GE, ALU_GEU: t = ~less;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ch0re_branch_unit_if.sv
// EX-to-branch-unit bundle; master is the EX stage, slave is the branch unit.
// Perf counter signals exist only when CH0RE_BRU_PERF_EN is defined.
interface ch0re_branch_unit_if #(
  parameter int unsigned XLEN = ch0re_types::XLEN
);
  import ch0re_types::*;

  logic            i_valid;
  logic            o_ready;
  alu_op_e         i_op;
  logic            i_is_jal;
  logic            i_is_jalr;
  logic            i_flag_zero;
  logic            i_flag_less;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_rs1;
  logic            i_pred_taken;
  logic [XLEN-1:0] i_pred_target;
  logic            o_res_valid;
  logic            o_taken;
  logic [XLEN-1:0] o_link;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_misaligned;
  logic            o_squash;
`ifdef CH0RE_BRU_PERF_EN
  logic [63:0]     o_perf_branches;
  logic [63:0]     o_perf_mispredicts;
`endif

  modport master (
    output i_valid, i_op, i_is_jal, i_is_jalr, i_flag_zero, i_flag_less,
           i_pc, i_imm, i_rs1, i_pred_taken, i_pred_target,
`ifdef CH0RE_BRU_PERF_EN
    input  o_perf_branches, o_perf_mispredicts,
`endif
    input  o_ready, o_res_valid, o_taken, o_link, o_redirect, o_redirect_pc,
           o_misaligned, o_squash
  );

  modport slave (
    input  i_valid, i_op, i_is_jal, i_is_jalr, i_flag_zero, i_flag_less,
           i_pc, i_imm, i_rs1, i_pred_taken, i_pred_target,
`ifdef CH0RE_BRU_PERF_EN
    output o_perf_branches, o_perf_mispredicts,
`endif
    output o_ready, o_res_valid, o_taken, o_link, o_redirect, o_redirect_pc,
           o_misaligned, o_squash
  );

endinterface

// File: rtl/ch0re_bru_cond.sv
// Combinational branch resolution: direction, target, link, next PC, mispredict
// and misalignment for the instruction currently in EX.
module ch0re_bru_cond #(
  parameter int unsigned XLEN = ch0re_types::XLEN
) (
  input  ch0re_types::alu_op_e op_i,
  input  logic                 is_jal_i,
  input  logic                 is_jalr_i,
  input  logic                 flag_zero_i,
  input  logic                 flag_less_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      rs1_i,
  input  logic                 pred_taken_i,
  input  logic [XLEN-1:0]      pred_target_i,
  output logic                 taken_o,
  output logic [XLEN-1:0]      target_o,
  output logic [XLEN-1:0]      link_o,
  output logic [XLEN-1:0]      next_pc_o,
  output logic                 mispredict_o,
  output logic                 misaligned_o
);
  import ch0re_types::*;

  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = rs1_i + imm_i;

  // jalr wins when both jump flags are set; that combination is illegal anyway.
  always_comb begin
    taken_o  = is_jal_i | is_jalr_i | branch_taken(op_i, flag_zero_i, flag_less_i);
    target_o = pc_i + imm_i;
    if (is_jalr_i) begin
      target_o = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign link_o       = pc_i + XLEN'(PC_STEP);
  assign next_pc_o    = taken_o ? target_o : link_o;
  assign mispredict_o = (taken_o != pred_taken_i) | (taken_o & (target_o != pred_target_i));
  assign misaligned_o = taken_o & (target_o[1:0] != 2'b00);

endmodule

// File: rtl/ch0re_branch_unit.sv
// Branch unit top: registers the resolution, drives redirect and the wrong-path squash window.
// Build with CH0RE_BRU_PERF_EN to add saturating branch/mispredict counters.
//
// state        | meaning
// BRU_IDLE     | resolving instructions normally
// BRU_REDIRECT | redirect pulse on outputs; accepted instructions are dropped
// BRU_SQUASH   | o_squash high for SQUASH_CYCLES cycles; accepted instructions are dropped
module ch0re_branch_unit #(
  parameter int unsigned XLEN          = ch0re_types::XLEN,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input logic                i_clk,
  input logic                i_rst,
  ch0re_branch_unit_if.slave bru
);
  import ch0re_types::*;

  localparam int unsigned CW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

  bru_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            res_valid_q, res_valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misaligned_q, misaligned_d;

  logic            c_taken;
  logic [XLEN-1:0] c_target;
  logic [XLEN-1:0] c_link;
  logic [XLEN-1:0] c_next_pc;
  logic            c_mispredict;
  logic            c_misaligned;
  logic            live;
  logic            redirect_now;

  ch0re_bru_cond #(.XLEN(XLEN)) u_cond (
    .op_i          (bru.i_op),
    .is_jal_i      (bru.i_is_jal),
    .is_jalr_i     (bru.i_is_jalr),
    .flag_zero_i   (bru.i_flag_zero),
    .flag_less_i   (bru.i_flag_less),
    .pc_i          (bru.i_pc),
    .imm_i         (bru.i_imm),
    .rs1_i         (bru.i_rs1),
    .pred_taken_i  (bru.i_pred_taken),
    .pred_target_i (bru.i_pred_target),
    .taken_o       (c_taken),
    .target_o      (c_target),
    .link_o        (c_link),
    .next_pc_o     (c_next_pc),
    .mispredict_o  (c_mispredict),
    .misaligned_o  (c_misaligned)
  );

  assign bru.o_ready = 1'b1;

  // Only IDLE-state accepts are on the correct path.
  assign live         = bru.i_valid & bru.o_ready & (state_q == BRU_IDLE);
  assign redirect_now = live & c_mispredict & ~c_misaligned;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    res_valid_d   = live;
    redirect_d    = redirect_now;
    misaligned_d  = live & c_misaligned;
    taken_d       = taken_q;
    link_d        = link_q;
    redirect_pc_d = redirect_pc_q;
    if (live) begin
      taken_d       = c_taken;
      link_d        = c_link;
      redirect_pc_d = c_next_pc;
    end
    unique case (state_q)
      BRU_IDLE: begin
        if (redirect_now) state_d = BRU_REDIRECT;
      end
      BRU_REDIRECT: begin
        state_d = BRU_SQUASH;
        cnt_d   = CW'(SQUASH_CYCLES - 1);
      end
      BRU_SQUASH: begin
        if (cnt_q == '0) state_d = BRU_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = BRU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= BRU_IDLE;
      cnt_q         <= '0;
      res_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      link_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      res_valid_q   <= res_valid_d;
      taken_q       <= taken_d;
      link_q        <= link_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign bru.o_res_valid   = res_valid_q;
  assign bru.o_taken       = taken_q;
  assign bru.o_link        = link_q;
  assign bru.o_redirect    = redirect_q;
  assign bru.o_redirect_pc = redirect_pc_q;
  assign bru.o_misaligned  = misaligned_q;
  assign bru.o_squash      = (state_q == BRU_SQUASH);

`ifdef CH0RE_BRU_PERF_EN
  logic [63:0] perf_br_q, perf_br_d;
  logic [63:0] perf_mp_q, perf_mp_d;

  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (live && (perf_br_q != '1))         perf_br_d = perf_br_q + 64'd1;
    if (redirect_now && (perf_mp_q != '1)) perf_mp_d = perf_mp_q + 64'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign bru.o_perf_branches    = perf_br_q;
  assign bru.o_perf_mispredicts = perf_mp_q;
`endif

  a_jump_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    bru.i_valid |-> !(bru.i_is_jal && bru.i_is_jalr));

endmodule
